alu8_sequencer: RTL and testbench
=================================

# alu8_sequencer

Accumulator-based command sequencer that drives the team's 8-bit combinational ALU from the issuing side. It accepts operate/load commands over a valid/ready handshake and presents registered operands and opcode to the ALU. It captures the ALU result and carry into an internal accumulator and returns each result over a second valid/ready handshake. It sits between the control path and the ALU datapath and is the only block that drives ALU inputs.

## Interface
- No parameters; widths are fixed at 8-bit data and 3-bit ALU opcode.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command; high only in IDLE.
- cmd_op  in  4  bit3=0: ALU op, S=cmd_op[2:0]; 8=LOAD; 9=CLEAR; 10–15 reserved.
- cmd_data  in  8  operand (ALU B input, or LOAD value).
- alu_a  out  8  registered ALU A input (= ACC).
- alu_b  out  8  registered ALU B input.
- alu_s  out  3  registered ALU opcode.
- alu_r  in  8  ALU combinational result.
- alu_co  in  1  ALU carry-out; meaningful for S=0 only.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_data  out  8  ACC value after the command.
- res_co  out  1  carry flag after the command.
- res_zero  out  1  res_data == 0.
- res_err  out  1  command was a reserved opcode.

## Operation
- State: ACC[7:0], CF, ERR, FSM {IDLE, EXEC, RESP}.
- The ALU opcode map used by the bench model is:
  - 0: A+B with carry.
  - 1: A−B.
  - 2: A+2B.
  - 3: A−2B.
  - 4: A^B.
  - 5: larger of A and B, unsigned.
  - 6: two's-complement abs(A).
  - 7: B.
  - Results are mod 256. Carry is 0 for S≠0.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, the command is accepted at that edge.
- ALU op accepted: alu_a<=ACC, alu_b<=cmd_data, alu_s<=cmd_op[2:0], ERR<=0. Go to EXEC.
- LOAD accepted: ACC<=cmd_data, CF<=0, ERR<=0. Go directly to RESP.
- CLEAR accepted: ACC<=0, CF<=0, ERR<=0. Go to RESP.
- Reserved op accepted: ACC and CF unchanged, ERR<=1. Go to RESP.
- EXEC lasts one cycle: ACC<=alu_r, CF<=alu_co, then go to RESP. alu_a/alu_b/alu_s hold their values until the next ALU op is accepted.
- RESP:
  - res_valid=1.
  - res_data=ACC, res_co=CF, res_zero=(ACC==0), res_err=ERR.
  - On res_ready, go to IDLE.
- cmd_ready=0 in EXEC and RESP. Commands are never queued or dropped while cmd_ready is low.

## Timing
- Reset values:
  - FSM=IDLE, ACC=0, CF=0, ERR=0.
  - alu_a=alu_b=0, alu_s=0.
  - cmd_ready=1, res_valid=0.
  - res_data=0, res_co=0, res_zero=1, res_err=0.
- Latency, with accept at edge N:
  - ALU op: res_valid is high after edge N+1.
  - LOAD, CLEAR and reserved ops: res_valid is high after edge N.
- The ALU input timing contract depends on the same-cycle ALU path:
  - ALU inputs are stable for the full EXEC cycle.
  - alu_r is sampled at the end of EXEC.
  - The ALU path must settle within one clock.
- Handshake outputs:
  - res_valid stays high, with res_* stable, until res_valid&&res_ready.
  - If res_ready is already high on entry, RESP lasts exactly one cycle.
  - cmd_ready rises in the cycle after the result transfer.
- Throughput:
  - ALU ops: one per 3 cycles.
  - LOAD, CLEAR and reserved ops: one per 2 cycles.
- Reset asserted mid-operation:
  - Takes effect immediately and asynchronously.
  - The in-flight command is discarded and no res_valid is produced.
  - After release, the first command is accepted on the first edge with cmd_valid.

## Test plan
- Carry on add: LOAD 0xF0, then op0 with 0x20 -> res_data=0x10, res_co=1, res_zero=0. The following LOAD 0x01 returns res_co=0.
- Subtract and zero flag:
  - LOAD 0x05, then op1 with 0x07 -> 0xFE, res_co=0.
  - Then op1 with 0xFE -> 0x00, res_zero=1.
- Max and abs:
  - LOAD 0x10, then op5 with 0x30 -> 0x30.
  - LOAD 0xFB, then op6 -> 0x05.
  - LOAD 0x80, then op6 -> 0x80.
- Backpressure:
  - Hold res_ready=0 for 5 cycles after res_valid -> res_* stable and cmd_ready=0 throughout.
  - A cmd_valid pulse presented during that time is not accepted.
- Reserved and CLEAR:
  - LOAD 0x42, then op 12 -> res_data=0x42, res_err=1.
  - Then op 9 -> res_data=0x00, res_err=0, res_zero=1.
- Reset mid-operation: assert rst during EXEC -> all outputs at reset values within the same cycle, no res_valid, and the next LOAD 0x11 returns 0x11.

Source files
------------

// File: rtl/alu8_sequencer.sv
// rtl/alu8_sequencer.sv - accumulator command sequencer driving an 8-bit combinational ALU
//
// Accepts ALU/LOAD/CLEAR commands on a valid/ready handshake, presents
// registered operands to the external ALU, captures its result into the
// accumulator and returns each result on a second valid/ready handshake.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   cmd_valid  in   command present
//   cmd_ready  out  command accepted this cycle (IDLE only)
//   cmd_op     in   [3]=0: ALU op cmd_op[2:0]; 8=LOAD; 9=CLEAR; 10-15 reserved
//   cmd_data   in   ALU B operand or LOAD value
//   alu_a      out  registered ALU A input (accumulator snapshot)
//   alu_b      out  registered ALU B input
//   alu_s      out  registered ALU opcode
//   alu_r      in   ALU result
//   alu_co     in   ALU carry-out
//   res_valid  out  result available
//   res_ready  in   consumer accepts result
//   res_data   out  accumulator after the command
//   res_co     out  carry flag after the command
//   res_zero   out  res_data == 0
//   res_err    out  command was a reserved opcode

module alu8_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [2:0] alu_s,
    input  logic [7:0] alu_r,
    input  logic       alu_co,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic       res_co,
    output logic       res_zero,
    output logic       res_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] OP_LOAD  = 4'd8;
    localparam logic [3:0] OP_CLEAR = 4'd9;

    state_t     r_state;
    logic [7:0] r_acc;
    logic       r_cf;
    logic       r_err;
    logic [7:0] r_alu_a;
    logic [7:0] r_alu_b;
    logic [2:0] r_alu_s;
    logic       r_cmd_ready;
    logic       r_res_valid;

    logic       w_acc_zero;

    assign w_acc_zero = (r_acc == 8'h00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_acc       <= 8'h00;
            r_cf        <= 1'b0;
            r_err       <= 1'b0;
            r_alu_a     <= 8'h00;
            r_alu_b     <= 8'h00;
            r_alu_s     <= 3'd0;
            r_cmd_ready <= 1'b1;
            r_res_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_cmd_ready <= 1'b0;
                        if (!cmd_op[3]) begin
                            // ALU inputs are frozen here so they stay stable
                            // for the whole EXEC cycle.
                            r_alu_a <= r_acc;
                            r_alu_b <= cmd_data;
                            r_alu_s <= cmd_op[2:0];
                            r_err   <= 1'b0;
                            r_state <= ST_EXEC;
                        end else begin
                            if (cmd_op == OP_LOAD) begin
                                r_acc <= cmd_data;
                                r_cf  <= 1'b0;
                                r_err <= 1'b0;
                            end else if (cmd_op == OP_CLEAR) begin
                                r_acc <= 8'h00;
                                r_cf  <= 1'b0;
                                r_err <= 1'b0;
                            end else begin
                                // Reserved: accumulator and carry untouched.
                                r_err <= 1'b1;
                            end
                            r_res_valid <= 1'b1;
                            r_state     <= ST_RESP;
                        end
                    end
                end
                ST_EXEC: begin
                    r_acc       <= alu_r;
                    r_cf        <= alu_co;
                    r_res_valid <= 1'b1;
                    r_state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_res_valid <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign res_valid = r_res_valid;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_s     = r_alu_s;
    assign res_data  = r_acc;
    assign res_co    = r_cf;
    assign res_zero  = w_acc_zero;
    assign res_err   = r_err;

endmodule

// File: tb/tb_alu8_sequencer.sv
// tb/tb_alu8_sequencer.sv - self-checking bench for alu8_sequencer

module tb_alu8_sequencer;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [7:0] cmd_data;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_s;
    logic [7:0] alu_r;
    logic       alu_co;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       res_co;
    logic       res_zero;
    logic       res_err;

    int n_cmp;
    int n_fail;

    alu8_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_s     (alu_s),
        .alu_r     (alu_r),
        .alu_co    (alu_co),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_co    (res_co),
        .res_zero  (res_zero),
        .res_err   (res_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model of the team ALU.
    always_comb begin
        logic [8:0] sum;
        sum    = 9'd0;
        alu_co = 1'b0;
        alu_r  = 8'h00;
        case (alu_s)
            3'd0: begin
                sum    = {1'b0, alu_a} + {1'b0, alu_b};
                alu_r  = sum[7:0];
                alu_co = sum[8];
            end
            3'd1: alu_r = alu_a - alu_b;
            3'd2: alu_r = alu_a + {alu_b[6:0], 1'b0};
            3'd3: alu_r = alu_a - {alu_b[6:0], 1'b0};
            3'd4: alu_r = alu_a ^ alu_b;
            3'd5: alu_r = (alu_a > alu_b) ? alu_a : alu_b;
            3'd6: alu_r = alu_a[7] ? (~alu_a + 8'd1) : alu_a;
            default: alu_r = alu_b;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " cmd_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, " res_valid"}, 32'(res_valid), 32'd0);
        check({tag, " res_data"},  32'(res_data),  32'd0);
        check({tag, " res_co"},    32'(res_co),    32'd0);
        check({tag, " res_zero"},  32'(res_zero),  32'd1);
        check({tag, " res_err"},   32'(res_err),   32'd0);
        check({tag, " alu_a"},     32'(alu_a),     32'd0);
        check({tag, " alu_b"},     32'(alu_b),     32'd0);
        check({tag, " alu_s"},     32'(alu_s),     32'd0);
    endtask

    // Issue one command with res_ready held high and check the response.
    task automatic do_cmd(input string tag, input logic [3:0] op, input logic [7:0] data,
                          input logic [7:0] exp_r, input logic exp_co,
                          input logic exp_z, input logic exp_err);
        int lat;
        @(negedge clk);
        check({tag, " cmd_ready"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!res_valid && lat < 10) begin
            lat++;
            @(negedge clk);
        end
        check({tag, " latency"}, 32'(lat), op[3] ? 32'd0 : 32'd1);
        check({tag, " res_data"}, 32'(res_data), 32'(exp_r));
        check({tag, " res_co"},   32'(res_co),   32'(exp_co));
        check({tag, " res_zero"}, 32'(res_zero), 32'(exp_z));
        check({tag, " res_err"},  32'(res_err),  32'(exp_err));
        if (!op[3]) begin
            check({tag, " alu_b"}, 32'(alu_b), 32'(data));
            check({tag, " alu_s"}, 32'(alu_s), 32'(op[2:0]));
        end
    endtask

    typedef struct {
        logic [3:0] op;
        logic [7:0] data;
        logic [7:0] r;
        logic       co;
        logic       z;
        logic       err;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs [NV];

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 4'd0;
        cmd_data  = 8'h00;
        res_ready = 1'b1;

        //           op     data   res    co    z     err
        vecs[0]  = '{4'd8,  8'hF0, 8'hF0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{4'd0,  8'h20, 8'h10, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{4'd8,  8'h01, 8'h01, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{4'd8,  8'h05, 8'h05, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{4'd1,  8'h07, 8'hFE, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{4'd1,  8'hFE, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{4'd8,  8'h10, 8'h10, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{4'd5,  8'h30, 8'h30, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{4'd8,  8'hFB, 8'hFB, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{4'd6,  8'h00, 8'h05, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{4'd8,  8'h80, 8'h80, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{4'd6,  8'h00, 8'h80, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{4'd2,  8'h03, 8'h86, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{4'd3,  8'h03, 8'h80, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{4'd4,  8'hFF, 8'h7F, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{4'd5,  8'h20, 8'h7F, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{4'd7,  8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[17] = '{4'd8,  8'h42, 8'h42, 1'b0, 1'b0, 1'b0};
        vecs[18] = '{4'd12, 8'h99, 8'h42, 1'b0, 1'b0, 1'b1};
        vecs[19] = '{4'd9,  8'h55, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[20] = '{4'd8,  8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0};
        vecs[21] = '{4'd0,  8'h01, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[22] = '{4'd15, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1};
        vecs[23] = '{4'd9,  8'h00, 8'h00, 1'b0, 1'b1, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1 check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Table-driven command sequence
        for (int i = 0; i < NV; i++) begin
            do_cmd($sformatf("vec%0d", i), vecs[i].op, vecs[i].data,
                   vecs[i].r, vecs[i].co, vecs[i].z, vecs[i].err);
        end

        // Back-to-back ALU ops: accept-to-accept spacing of 3 cycles
        begin
            int gap;
            do_cmd("tp_load", 4'd8, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0);
            do_cmd("tp_add", 4'd0, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0);
            // After the response check at a negedge, ready rises one edge later.
            gap = 0;
            @(negedge clk);
            while (!cmd_ready && gap < 10) begin
                gap++;
                @(negedge clk);
            end
            check("tp cmd_ready gap", 32'(gap), 32'd0);
        end

        // Backpressure: hold res_ready low, stray cmd_valid must be ignored
        res_ready = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 4'd8;
        cmd_data  = 8'h3C;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("bp%0d res_valid", c), 32'(res_valid), 32'd1);
            check($sformatf("bp%0d res_data", c),  32'(res_data),  32'h3C);
            check($sformatf("bp%0d cmd_ready", c), 32'(cmd_ready), 32'd0);
            if (c == 2) begin
                cmd_valid = 1'b1;
                cmd_op    = 4'd8;
                cmd_data  = 8'h99;
            end else begin
                cmd_valid = 1'b0;
            end
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        check("bp after cmd_ready", 32'(cmd_ready), 32'd1);
        check("bp after res_valid", 32'(res_valid), 32'd0);
        do_cmd("bp readback", 4'd10, 8'h00, 8'h3C, 1'b0, 1'b0, 1'b1);

        // Reset during EXEC
        do_cmd("rst_load", 4'd8, 8'h22, 8'h22, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 4'd0;
        cmd_data  = 8'h01;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        check("rst exec alu_b", 32'(alu_b), 32'h01);
        #1 rst = 1'b1;
        #1 check_reset_outputs("rst_mid");
        @(posedge clk);
        #1 check("rst hold res_valid", 32'(res_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check("rst post res_valid", 32'(res_valid), 32'd0);
        do_cmd("rst_reload", 4'd8, 8'h11, 8'h11, 1'b0, 1'b0, 1'b0);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
